// File: rtl/ecg_peak_detector.sv
// R-peak detector: tracks local maxima above a threshold, reports amplitude and R-R interval.
// Define ADAPTIVE_THRESH_EN for an internal self-adjusting threshold (thresh_in then unused).
module ecg_peak_detector #(
  parameter int unsigned                DATA_W      = 16,
  parameter int unsigned                RR_W        = 16,
  parameter int unsigned                REFRACT     = 72,
  parameter logic signed [DATA_W-1:0]   INIT_THRESH = DATA_W'(2000)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  input  logic [DATA_W-1:0] thresh_in,
  output logic              peak_valid,
  output logic [DATA_W-1:0] peak_amp,
  output logic [RR_W-1:0]   rr_interval,
  output logic              first_peak,
  output logic              rr_sat
);

  localparam logic [1:0] StSearch  = 2'd0;
  localparam logic [1:0] StTrack   = 2'd1;
  localparam logic [1:0] StRefract = 2'd2;
  localparam int unsigned CntW = $clog2(REFRACT + 2);

  // Distance counters carry one extra bit: MSB set means ">= 2^RR_W", i.e. saturated.
  function automatic logic [RR_W:0] sat_inc(input logic [RR_W:0] v);
    return v[RR_W] ? v : v + {{RR_W{1'b0}}, 1'b1};
  endfunction

  logic [1:0]               state_q, state_d;
  logic signed [DATA_W-1:0] cand_amp_q, cand_amp_d;
  logic [RR_W:0]            cand_off_q, cand_off_d;  // samples since candidate index
  logic [RR_W:0]            cand_rr_q, cand_rr_d;    // candidate index minus previous peak
  logic [RR_W:0]            dist_q, dist_d;          // next sample index minus previous peak
  logic [CntW-1:0]          ref_cnt_q, ref_cnt_d, ref_nxt;
  logic                     armed_q, armed_d;
  logic                     peak_valid_q, peak_valid_d;
  logic [DATA_W-1:0]        peak_amp_q, peak_amp_d;
  logic [RR_W-1:0]          rr_q, rr_d;
  logic                     first_q, first_d;
  logic                     rr_sat_q, rr_sat_d;
  logic                     declare;
  logic signed [DATA_W-1:0] thr;

`ifdef ADAPTIVE_THRESH_EN
  logic signed [DATA_W-1:0] thr_q, thr_d;
  logic signed [DATA_W:0]   thr_sum;
  logic                     unused_thresh_in;

  assign unused_thresh_in = ^thresh_in;
  assign thr = thr_q;

  always_comb begin
    thr_sum = ($signed({thr_q[DATA_W-1], thr_q}) >>> 1)
            + ($signed({cand_amp_q[DATA_W-1], cand_amp_q}) >>> 2);
    thr_d = thr_q;
    if (declare) begin
      if (thr_sum[DATA_W] != thr_sum[DATA_W-1]) begin
        thr_d = thr_sum[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
      end else begin
        thr_d = thr_sum[DATA_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) thr_q <= INIT_THRESH;
    else     thr_q <= thr_d;
  end
`else
  assign thr = $signed(thresh_in);
`endif

  always_comb begin
    state_d      = state_q;
    cand_amp_d   = cand_amp_q;
    cand_off_d   = cand_off_q;
    cand_rr_d    = cand_rr_q;
    dist_d       = dist_q;
    ref_cnt_d    = ref_cnt_q;
    ref_nxt      = ref_cnt_q + 1'b1;
    armed_d      = armed_q;
    peak_valid_d = 1'b0;
    peak_amp_d   = peak_amp_q;
    rr_d         = rr_q;
    first_d      = first_q;
    rr_sat_d     = rr_sat_q;
    declare      = 1'b0;
    if (s_valid) begin
      dist_d     = sat_inc(dist_q);
      cand_off_d = sat_inc(cand_off_q);
      case (state_q)
        StSearch: begin
          if ($signed(s_data) > thr) begin
            state_d    = StTrack;
            cand_amp_d = $signed(s_data);
            cand_off_d = {{RR_W{1'b0}}, 1'b1};
            cand_rr_d  = dist_q;
          end
        end
        StTrack: begin
          if ($signed(s_data) > cand_amp_q) begin
            cand_amp_d = $signed(s_data);
            cand_off_d = {{RR_W{1'b0}}, 1'b1};
            cand_rr_d  = dist_q;
          end else if ($signed(s_data) < cand_amp_q) begin
            declare = 1'b1;
          end
        end
        StRefract: begin
          if (32'(ref_nxt) >= REFRACT) state_d = StSearch;
          else                         ref_cnt_d = ref_nxt;
        end
        default: state_d = StSearch;
      endcase
      if (declare) begin
        // The declaring sample is the first refractory sample.
        state_d      = (REFRACT <= 1) ? StSearch : StRefract;
        ref_cnt_d    = CntW'(1);
        dist_d       = sat_inc(cand_off_q);
        armed_d      = 1'b0;
        peak_valid_d = 1'b1;
        peak_amp_d   = cand_amp_q;
        first_d      = armed_q;
        rr_sat_d     = !armed_q && cand_rr_q[RR_W];
        if (armed_q)             rr_d = '0;
        else if (cand_rr_q[RR_W]) rr_d = '1;
        else                     rr_d = cand_rr_q[RR_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StSearch;
      cand_amp_q   <= '0;
      cand_off_q   <= '0;
      cand_rr_q    <= '0;
      dist_q       <= '0;
      ref_cnt_q    <= '0;
      armed_q      <= 1'b1;
      peak_valid_q <= 1'b0;
      peak_amp_q   <= '0;
      rr_q         <= '0;
      first_q      <= 1'b0;
      rr_sat_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      cand_amp_q   <= cand_amp_d;
      cand_off_q   <= cand_off_d;
      cand_rr_q    <= cand_rr_d;
      dist_q       <= dist_d;
      ref_cnt_q    <= ref_cnt_d;
      armed_q      <= armed_d;
      peak_valid_q <= peak_valid_d;
      peak_amp_q   <= peak_amp_d;
      rr_q         <= rr_d;
      first_q      <= first_d;
      rr_sat_q     <= rr_sat_d;
    end
  end

  assign peak_valid  = peak_valid_q;
  assign peak_amp    = peak_amp_q;
  assign rr_interval = rr_q;
  assign first_peak  = first_q;
  assign rr_sat      = rr_sat_q;

endmodule

// File: tb/tb_ecg_peak_detector.sv
// Randomized + directed bench for ecg_peak_detector against an index-based reference model.
module tb_ecg_peak_detector;
  localparam int REFRACT = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        s_valid = 1'b0;
  logic [15:0] s_data = '0;
  logic [15:0] thresh_in = '0;
  logic        peak_valid, first_peak, rr_sat;
  logic [15:0] peak_amp, rr_interval;

  always #5 clk = ~clk;

  ecg_peak_detector #(
    .DATA_W     (16),
    .RR_W       (16),
    .REFRACT    (REFRACT),
`ifdef ADAPTIVE_THRESH_EN
    .INIT_THRESH(16'sd100)
`else
    .INIT_THRESH(16'sd2000)
`endif
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .s_valid    (s_valid),
    .s_data     (s_data),
    .thresh_in  (thresh_in),
    .peak_valid (peak_valid),
    .peak_amp   (peak_amp),
    .rr_interval(rr_interval),
    .first_peak (first_peak),
    .rr_sat     (rr_sat)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: absolute sample indices, refractory expressed as a resume index.
  longint m_k, m_cidx, m_prev, m_resume;
  int     m_camp, m_thr;
  bit     m_track, m_armed;
  bit     e_pv, e_first, e_sat;
  int     e_amp, e_rr;

  task automatic model_reset();
    m_k = 0; m_cidx = 0; m_prev = 0; m_resume = 0; m_camp = 0; m_thr = 100;
    m_track = 0; m_armed = 1;
    e_pv = 0; e_first = 0; e_sat = 0; e_amp = 0; e_rr = 0;
  endtask

  task automatic model_step(input bit v, input logic [15:0] d);
    int     x, thr, t;
    longint diff;
    e_pv = 0;
    if (!v) return;
    x = int'($signed(d));
`ifdef ADAPTIVE_THRESH_EN
    thr = m_thr;
`else
    thr = int'($signed(thresh_in));
`endif
    if (m_k < m_resume) begin
      // ignored refractory sample
    end else if (!m_track) begin
      if (x > thr) begin m_track = 1; m_camp = x; m_cidx = m_k; end
    end else if (x > m_camp) begin
      m_camp = x; m_cidx = m_k;
    end else if (x < m_camp) begin
      e_pv = 1; e_amp = m_camp; e_first = m_armed;
      diff = m_cidx - m_prev;
      e_sat = !m_armed && (diff > 65535);
      e_rr = m_armed ? 0 : (diff > 65535 ? 65535 : int'(diff));
      m_armed = 0; m_prev = m_cidx; m_track = 0;
      m_resume = m_k + ((REFRACT < 1) ? 1 : REFRACT);
      t = (m_thr >>> 1) + (m_camp >>> 2);
      m_thr = (t > 32767) ? 32767 : ((t < -32768) ? -32768 : t);
    end
    m_k++;
  endtask

  int          n_pk;
  logic [15:0] l_amp, l_rr;
  logic        l_first, l_sat;

  task automatic cycle(input bit v, input logic [15:0] d);
    @(negedge clk);
    if (peak_valid) begin
      n_pk++; l_amp = peak_amp; l_rr = rr_interval; l_first = first_peak; l_sat = rr_sat;
    end
    check("peak_valid", peak_valid, e_pv);
    check("peak_amp", peak_amp, e_amp[15:0]);
    check("rr_interval", rr_interval, e_rr[15:0]);
    check("first_peak", first_peak, e_first);
    check("rr_sat", rr_sat, e_sat);
    model_step(v, d);
    s_valid = v;
    s_data  = d;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    s_valid = 1'b0;
    #1;
    check("rst_peak_valid", peak_valid, 0);
    check("rst_peak_amp", peak_amp, 0);
    check("rst_rr_interval", rr_interval, 0);
    check("rst_first_peak", first_peak, 0);
    check("rst_rr_sat", rr_sat, 0);
    model_reset();
    n_pk = 0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    model_reset();
    n_pk = 0;
    do_reset();
`ifndef ADAPTIVE_THRESH_EN
    begin
      int t2[6] = '{0, 50, 150, 300, 200, 0};
      int t3[11] = '{500, 0, 0, 0, 0, 0, 200, 400, 100, 0, 0};
      bit v4[17] = '{1, 0, 1, 0, 0, 1, 0, 1, 1, 1, 1, 1, 1, 0, 1, 1, 1};
      int d4[17] = '{0, 999, 300, 0, 0, 300, 0, 200, 0, 0, 0, 0, 300, 0, 300, 100, 0};
      thresh_in = 16'd100;
      foreach (t2[i]) cycle(1'b1, 16'(t2[i]));
      check("t2_npk", n_pk, 1);
      check("t2_amp", l_amp, 300);
      check("t2_rr", l_rr, 0);
      check("t2_first", l_first, 1);
      foreach (t3[i]) cycle(1'b1, 16'(t3[i]));
      check("t3_npk", n_pk, 2);
      check("t3_amp", l_amp, 400);
      check("t3_rr", l_rr, 10);
      check("t3_first", l_first, 0);

      do_reset();
      foreach (d4[i]) cycle(v4[i], 16'(d4[i]));
      cycle(1'b0, 16'd0);
      check("t4_npk", n_pk, 2);
      check("t4_amp", l_amp, 300);
      check("t4_rr", l_rr, 7);

      do_reset();
      cycle(1'b1, 16'd0);
      cycle(1'b1, 16'd500);
      cycle(1'b1, 16'd0);
      repeat (70000) cycle(1'b1, 16'd0);
      cycle(1'b1, 16'd500);
      cycle(1'b1, 16'd0);
      cycle(1'b1, 16'd0);
      check("t5_npk", n_pk, 2);
      check("t5_rr", l_rr, 65535);
      check("t5_sat", l_sat, 1);
    end
`else
    begin
      int t6[13] = '{0, 1000, 0, 0, 0, 0, 0, 250, 0, 0, 400, 0, 0};
      thresh_in = 16'd0;
      foreach (t6[i]) cycle(1'b1, 16'(t6[i]));
      check("t6_npk", n_pk, 2);
      check("t6_amp", l_amp, 400);
    end
`endif

    do_reset();
    for (int i = 0; i < 3000; i++) begin
      logic [15:0] d;
      if (i % 200 == 0) thresh_in = 16'($urandom_range(0, 400));
      if ($urandom_range(0, 599) == 0) do_reset();
      if ($urandom_range(0, 49) == 0) d = 16'($urandom);
      else                            d = 16'(int'($urandom_range(0, 8)) * 100 - 200);
      cycle($urandom_range(0, 3) != 0, d);
    end
    cycle(1'b0, 16'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
